// File: rtl/write_bram_pkg.sv
// rtl/write_bram_pkg.sv - shared state encoding and FIFO sizing for write_bram
package write_bram_pkg;

    typedef enum logic {
        FSM_IDLE  = 1'b0,
        FSM_WRITE = 1'b1
    } fsm_e;

    localparam int FIFO_NUM_SLOTS     = 2;
    localparam int FIFO_LOG_NUM_SLOTS = 1;

endpackage

// File: rtl/write_bram_fifo.sv
// rtl/write_bram_fifo.sv - small power-of-two slot FIFO with full/almost_full/empty flags
module write_bram_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_SLOTS     = 2,
    parameter int LOG_NUM_SLOTS = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty
);

    localparam logic [LOG_NUM_SLOTS:0] FULL_COUNT   = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
    localparam logic [LOG_NUM_SLOTS:0] ALMOST_COUNT = (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1);

    logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0]    mem_d [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_NUM_SLOTS:0]   count_q, count_d;
    logic                     do_push;
    logic                     do_pop;

    assign full        = (count_q == FULL_COUNT);
    assign almost_full = (count_q >= ALMOST_COUNT);
    assign empty       = (count_q == '0);
    assign head_data   = mem_q[rd_ptr_q];
    assign do_push     = push & ~full;
    assign do_pop      = pop & ~empty;

    // Next-state for storage, pointers and occupancy; simultaneous push/pop keeps count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + LOG_NUM_SLOTS'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + LOG_NUM_SLOTS'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (LOG_NUM_SLOTS+1)'(1);
            2'b01:   count_d = count_q - (LOG_NUM_SLOTS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by the active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are meaningless while count is zero so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/write_bram.sv
// rtl/write_bram.sv - buffers an upstream stream and issues iterated block RAM writes
module write_bram
    import write_bram_pkg::*;
#(
    parameter int    DATA_WIDTH              = 8,
    parameter int    LOG_MAX_ITERS           = 16,
    parameter int    LOG_MAX_WRITES_PER_ITER = 16,
    parameter int    LOG_MAX_ADDRESS         = 16,
    parameter string TYPE                    = "unspecified"
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               configure,
    input  logic [LOG_MAX_ITERS-1:0]           num_iters,
    input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
    input  logic [LOG_MAX_ADDRESS-1:0]         base_address,
    input  logic                               valid_in,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic                               avail_out,
    output logic [LOG_MAX_ADDRESS-1:0]         address_out,
    output logic                               write_out,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               busy,
    output logic                               done
);

    // TYPE only tags the instance in the hierarchy; it has no functional effect
    if (TYPE == "") begin : g_untagged_instance
    end

    fsm_e                               state_q, state_d;
    logic [LOG_MAX_ITERS-1:0]           iters_q, iters_d;
    logic [LOG_MAX_WRITES_PER_ITER-1:0] wpi_q, wpi_d;
    logic [LOG_MAX_WRITES_PER_ITER-1:0] wpi_copy_q, wpi_copy_d;
    logic [LOG_MAX_ADDRESS-1:0]         addr_q, addr_d;
    logic [LOG_MAX_ADDRESS-1:0]         addr_copy_q, addr_copy_d;
    logic [LOG_MAX_ADDRESS-1:0]         address_out_q, address_out_d;
    logic                               write_out_q, write_out_d;
    logic [DATA_WIDTH-1:0]              data_out_q, data_out_d;
    logic                               done_q, done_d;

    logic                  enabled;
    logic                  accept;
    logic                  issue_w;
    logic                  fifo_resetn;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_almost_full;
    logic                  fifo_empty;

    assign enabled     = (state_q == FSM_WRITE);
    assign accept      = valid_in & ~fifo_full & enabled & ~configure;
    assign issue_w     = enabled & ~fifo_empty & ~configure;
    assign fifo_resetn = ~(rst | configure);

    // Only offer space when both slots are free so a valid issued on a stale avail still fits
    assign avail_out   = enabled & ~fifo_full & ~fifo_almost_full;
    assign busy        = enabled;
    assign address_out = address_out_q;
    assign write_out   = write_out_q;
    assign data_out    = data_out_q;
    assign done        = done_q;

    write_bram_fifo #(
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_SLOTS     (FIFO_NUM_SLOTS),
        .LOG_NUM_SLOTS (FIFO_LOG_NUM_SLOTS)
    ) fifo_in (
        .clk         (clk),
        .resetn      (fifo_resetn),
        .push        (accept),
        .push_data   (data_in),
        .pop         (issue_w),
        .head_data   (fifo_head),
        .full        (fifo_full),
        .almost_full (fifo_almost_full),
        .empty       (fifo_empty)
    );

    // Configure loads the counters; each issued word advances address/iteration counters
    always_comb begin
        state_d       = state_q;
        iters_d       = iters_q;
        wpi_d         = wpi_q;
        wpi_copy_d    = wpi_copy_q;
        addr_d        = addr_q;
        addr_copy_d   = addr_copy_q;
        address_out_d = address_out_q;
        data_out_d    = data_out_q;
        write_out_d   = 1'b0;
        done_d        = 1'b0;
        if (configure) begin
            iters_d     = num_iters;
            wpi_d       = num_writes_per_iter;
            wpi_copy_d  = num_writes_per_iter;
            addr_d      = base_address;
            addr_copy_d = base_address;
            if ((num_iters == '0) || (num_writes_per_iter == '0)) begin
                state_d = FSM_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = FSM_WRITE;
            end
        end else if (issue_w) begin
            write_out_d   = 1'b1;
            address_out_d = addr_q;
            data_out_d    = fifo_head;
            if (wpi_q != LOG_MAX_WRITES_PER_ITER'(1)) begin
                wpi_d  = wpi_q - LOG_MAX_WRITES_PER_ITER'(1);
                addr_d = addr_q + LOG_MAX_ADDRESS'(1);
            end else if (iters_q != LOG_MAX_ITERS'(1)) begin
                iters_d = iters_q - LOG_MAX_ITERS'(1);
                wpi_d   = wpi_copy_q;
                addr_d  = addr_copy_q;
            end else begin
                state_d = FSM_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // State, counter and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FSM_IDLE;
            iters_q       <= '0;
            wpi_q         <= '0;
            wpi_copy_q    <= '0;
            addr_q        <= '0;
            addr_copy_q   <= '0;
            address_out_q <= '0;
            write_out_q   <= 1'b0;
            data_out_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            iters_q       <= iters_d;
            wpi_q         <= wpi_d;
            wpi_copy_q    <= wpi_copy_d;
            addr_q        <= addr_d;
            addr_copy_q   <= addr_copy_d;
            address_out_q <= address_out_d;
            write_out_q   <= write_out_d;
            data_out_q    <= data_out_d;
            done_q        <= done_d;
        end
    end

endmodule
